// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and the multiplier FSM state type.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 8;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-and-add multiplier datapath: operand shifters, accumulator and iteration counter.
module mul_shift_add_dp
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_sum_o,
   output logic               last_o
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_sum;

   // Accumulator value after the current step; also the final product on the last step.
   always_comb begin
      acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign acc_sum_o = acc_sum;
   assign last_o    = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/mul_shift_add_8bit.sv
// Multi-cycle unsigned multiplier: start/busy/done control FSM around the shift-add datapath.
module mul_shift_add_8bit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   mul_state_t         state_q, state_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               accept;
   logic               step;
   logic               last;
   logic [2*WIDTH-1:0] acc_sum;

   // Start is only honoured when no operation is in flight.
   assign accept = start && ((state_q == MUL_IDLE) || (state_q == MUL_DONE));
   assign step   = (state_q == MUL_RUN);

   mul_shift_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk       (clk),
      .reset     (reset),
      .load_i    (accept),
      .step_i    (step),
      .a_i       (a),
      .b_i       (b),
      .acc_sum_o (acc_sum),
      .last_o    (last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MUL_IDLE: if (start) state_d = MUL_RUN;
         MUL_RUN:  if (last) state_d = MUL_DONE;
         MUL_DONE: state_d = start ? MUL_RUN : MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
   end

   always_comb begin
      product_d = product_q;
      if (step && last) begin
         product_d = acc_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MUL_IDLE;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == MUL_RUN);
   assign done    = (state_q == MUL_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_mul_shift_add_8bit.sv
// Self-checking bench for mul_shift_add_8bit: directed cases plus random operands vs a*b.
module tb_mul_shift_add_8bit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] prod_m = 16'd0;

   mul_shift_add_8bit dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      start = 1'b0;
      tick();
      chk("idle_busy", {15'd0, busy}, 16'd0);
      chk("idle_done", {15'd0, done}, 16'd0);
      chk("idle_prod", product, prod_m);
   endtask

   // Issues one multiply from the current cycle; returns with the DONE cycle visible.
   task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input bit poke);
      a     = oa;
      b     = ob;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         chk("run_busy", {15'd0, busy}, 16'd1);
         chk("run_done", {15'd0, done}, 16'd0);
         chk("run_hold", product, prod_m);
         if (poke && i == 3) begin
            a     = 8'd1;
            b     = 8'd1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start  = 1'b0;
      prod_m = 16'(oa) * 16'(ob);
      chk("fin_done", {15'd0, done}, 16'd1);
      chk("fin_busy", {15'd0, busy}, 16'd0);
      chk("fin_prod", product, prod_m);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a     = 8'd0;
      b     = 8'd0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) idle_cycle();

      do_op(8'd15, 8'd15, 1'b0);
      chk("p225", product, 16'd225);
      idle_cycle();
      do_op(8'd255, 8'd255, 1'b0);
      chk("pfe01", product, 16'hFE01);
      idle_cycle();
      do_op(8'd0, 8'd200, 1'b0);
      idle_cycle();

      // Mid-run start is ignored, then back-to-back issue from the DONE cycle.
      do_op(8'd12, 8'd10, 1'b1);
      chk("p120", product, 16'd120);
      do_op(8'd3, 8'd7, 1'b0);
      chk("p21", product, 16'd21);
      idle_cycle();

      // Reset during the fourth RUN cycle aborts the operation.
      a     = 8'd9;
      b     = 8'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_rst_busy", {15'd0, busy}, 16'd1);
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      prod_m = 16'd0;
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_prod", product, 16'd0);
      for (int i = 0; i < 10; i++) idle_cycle();
      do_op(8'd9, 8'd9, 1'b0);
      chk("p81", product, 16'd81);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 2) != 0) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cycle();
         end
         do_op(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
      end
      idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
